// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss handler: on a miss, fetch the whole block from
// main memory using back-to-back pipelined reads, stream each returned word
// into the data array, and write the tag once the final word lands.
// fsm_busy holds the fetch path stalled for the whole fill.
module icache_fill_fsm #(
  parameter  int BLOCK_WORDS = 8,
  parameter  int ADDR_W      = 16,
  parameter  int DATA_W      = 16,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic [ADDR_W-1:0] memory_address,
  output logic              mem_read,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  word_index,
  output logic [DATA_W-1:0] cache_data,
  output logic              write_tag_array
);

  // Counters need one extra bit so "all words requested" is representable.
  localparam int CNT_W  = IDX_W + 1;
  // Byte-offset bits inside a block (block = 2*BLOCK_WORDS bytes).
  localparam int OFF_W  = IDX_W + 1;
  localparam int BASE_W = ADDR_W - OFF_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  resp_cnt_q, resp_cnt_d;
  // Only the block-aligned part of the miss address is kept; the offset
  // bits are always zero and are rebuilt from the request counter.
  logic [BASE_W-1:0] base_q, base_d;

  // The byte offset of the missing address plays no part in the fill.
  logic              miss_offset_unused;
  assign miss_offset_unused = ^miss_address[OFF_W-1:0];

  // The returned word goes straight to the data array.
  assign cache_data = memory_data;
  assign word_index = resp_cnt_q[IDX_W-1:0];

  // State, counter and block-base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      base_q     <= base_d;
    end
  end

  // Next-state logic and all control outputs; requests and responses are
  // tracked independently so memory latency and response gaps do not matter.
  always_comb begin
    state_d          = state_q;
    req_cnt_d        = req_cnt_q;
    resp_cnt_d       = resp_cnt_q;
    base_d           = base_q;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d    = FILL;
          base_d     = miss_address[ADDR_W-1:OFF_W];
          req_cnt_d  = '0;
          resp_cnt_d = '0;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        // Issue one read per cycle until every word of the block is requested.
        // The offset is spliced in rather than added, so it never carries
        // out of the block.
        if (req_cnt_q != CNT_FULL) begin
          mem_read       = 1'b1;
          memory_address = {base_q, req_cnt_q[IDX_W-1:0], 1'b0};
          req_cnt_d      = req_cnt_q + 1'b1;
        end

        // Responses arrive in request order, so resp_cnt is the word slot.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          resp_cnt_d       = resp_cnt_q + 1'b1;
          if (resp_cnt_q == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
            req_cnt_d       = '0;
            resp_cnt_d      = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Testbench for icache_fill_fsm: a pipelined main-memory model answers the
// DUT's reads; expected requests, array writes and busy-run lengths are queued
// by the stimulus and consumed by an independent monitor.
module tb_icache_fill_fsm;
  localparam int BW = 8;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          fsm_busy;
  logic [AW-1:0] memory_address;
  logic          mem_read;
  logic          memory_data_valid;
  logic [DW-1:0] memory_data;
  logic          write_data_array;
  logic [IW-1:0] word_index;
  logic [DW-1:0] cache_data;
  logic          write_tag_array;

  icache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_address    (memory_address),
    .mem_read          (mem_read),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .cache_data        (cache_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          tag;
  } wr_t;

  typedef struct {
    int            rdy;
    logic [DW-1:0] d;
  } rsp_t;

  logic [AW-1:0] exp_addr_q[$];
  wr_t           exp_wr_q[$];
  int            exp_busy_q[$];
  rsp_t          rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, value 0x%0h, expected none", name, act);
  endtask

  // Main memory: a read issued in cycle c returns in cycle c+3 (4-cycle
  // memory). gap_mode releases responses only on a 1,0,0 pattern; spur forces
  // a bogus valid. Shares rst_n and drops in-flight reads on reset.
  bit            gap_mode = 1'b0;
  bit            spur     = 1'b0;
  int            cyc      = 0;
  int            phase    = 0;
  logic          mm_r;
  logic [AW-1:0] mm_a;
  rsp_t          mm_rsp;

  initial begin
    memory_data_valid = 1'b0;
    memory_data       = '0;
    forever begin
      @(negedge clk);
      mm_r = mem_read;
      mm_a = memory_address;
      @(posedge clk);
      #1;
      cyc++;
      memory_data_valid = 1'b0;
      memory_data       = '0;
      if (!rst_n) begin
        rsp_q.delete();
        phase = 0;
      end else begin
        if (mm_r) begin
          mm_rsp.rdy = cyc + 2;
          mm_rsp.d   = 16'hA000 + {13'd0, mm_a[3:1]};
          rsp_q.push_back(mm_rsp);
        end
        if (spur) begin
          memory_data_valid = 1'b1;
          memory_data       = 16'hDEAD;
        end else if (rsp_q.size() > 0 && rsp_q[0].rdy <= cyc) begin
          if (!gap_mode || (phase % 3) == 0) begin
            memory_data_valid = 1'b1;
            memory_data       = rsp_q[0].d;
            void'(rsp_q.pop_front());
          end
          phase++;
        end else if (rsp_q.size() == 0) begin
          phase = 0;
        end
      end
    end
  end

  // Monitor: checks every request, every array write and each busy run.
  int  busy_run = 0;
  wr_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_read) begin
        if (exp_addr_q.size() == 0) unexpected("mem_read", memory_address);
        else chk("memory_address", memory_address, exp_addr_q.pop_front());
      end
      if (write_data_array) begin
        if (exp_wr_q.size() == 0) unexpected("write_data_array", cache_data);
        else begin
          mon_e = exp_wr_q.pop_front();
          chk("word_index", word_index, mon_e.idx);
          chk("cache_data", cache_data, mon_e.data);
          chk("write_tag_array", write_tag_array, mon_e.tag);
        end
      end else if (write_tag_array) begin
        unexpected("tag_without_write", word_index);
      end
      if (fsm_busy) busy_run++;
      else if (busy_run > 0) begin
        if (exp_busy_q.size() == 0) unexpected("busy_run", busy_run);
        else chk("busy_len", busy_run, exp_busy_q.pop_front());
        busy_run = 0;
      end
    end
  end

  // Queue the expected traffic of one fill from a block base address.
  task automatic push_fill(input logic [AW-1:0] base, input int nreq, input int nwr,
                           input bit tag, input int busy);
    wr_t w;
    for (int i = 0; i < nreq; i++) exp_addr_q.push_back(base + AW'(2 * i));
    for (int i = 0; i < nwr; i++) begin
      w.idx  = IW'(i);
      w.data = 16'hA000 + DW'(i);
      w.tag  = tag && (i == BW - 1);
      exp_wr_q.push_back(w);
    end
    exp_busy_q.push_back(busy);
  endtask

  // Raise a miss, hold it until busy falls, then drop it. chg_at >= 0 changes
  // miss_address that many cycles into the fill.
  task automatic run_miss(input logic [AW-1:0] addr, input int chg_at);
    int n;
    @(negedge clk);
    miss_address  = addr;
    miss_detected = 1'b1;
    @(negedge clk);
    chk("busy_rise", fsm_busy, 1);
    n = 0;
    while (fsm_busy && n < 100) begin
      if (n == chg_at) miss_address = 16'h5550;
      @(negedge clk);
      n++;
    end
    if (fsm_busy) unexpected("fill_timeout", n);
    miss_detected = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: reset with a miss pending
    rst_n         = 1'b0;
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_busy", fsm_busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", memory_address, 0);
    chk("rst_wda", write_data_array, 0);
    chk("rst_wta", write_tag_array, 0);
    chk("rst_word_index", word_index, 0);
    miss_detected = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", fsm_busy, 0);

    // 2: basic fill
    push_fill(16'h1230, 8, 8, 1'b1, 11);
    run_miss(16'h1234, -1);

    // 3: top of memory, no wrap to 0x0000
    push_fill(16'hFFF0, 8, 8, 1'b1, 11);
    run_miss(16'hFFFB, -1);

    // 4: bubbled responses 1,0,0,1,...
    gap_mode = 1'b1;
    push_fill(16'h0800, 8, 8, 1'b1, 25);
    run_miss(16'h0806, -1);
    gap_mode = 1'b0;

    // 5: spurious valids in IDLE, then miss_address changed mid-fill
    @(negedge clk);
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_no_write", write_data_array, 0);
      chk("spur_idle", fsm_busy, 0);
    end
    spur = 1'b0;
    @(negedge clk);
    push_fill(16'h2460, 8, 8, 1'b1, 11);
    run_miss(16'h2468, 3);

    // 6: reset after 5 writes, then a fresh fill
    push_fill(16'h3000, 8, 5, 1'b0, 8);
    @(negedge clk);
    miss_address  = 16'h3000;
    miss_detected = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge clk);
      #1;
      if (write_data_array) n++;
    end
    chk("mid_fill_writes", n, 5);
    #1;
    rst_n         = 1'b0;
    miss_detected = 1'b0;
    #1;
    chk("midrst_busy", fsm_busy, 0);
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_wda", write_data_array, 0);
    chk("midrst_wta", write_tag_array, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_fill(16'h0040, 8, 8, 1'b1, 11);
    run_miss(16'h0040, -1);

    repeat (6) @(negedge clk);
    chk("left_requests", exp_addr_q.size(), 0);
    chk("left_writes", exp_wr_q.size(), 0);
    chk("left_busy_runs", exp_busy_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
